// File: rtl/mem_read_responder.sv
// Single-outstanding read responder bridging an AR/R handshake onto a read-only SRAM port.
// Define MEM_RESP_RAND_DELAY_EN to draw the per-read wait count from an external rand_lfsr_8_bit instead of LATENCY.
module mem_read_responder #(
  parameter int unsigned          DATA_LEN   = 32,
  parameter logic [DATA_LEN-1:0]  BASE_ADDR  = DATA_LEN'(32'h8000_0000),
  parameter int unsigned          ADDR_WIDTH = 10,
  parameter int unsigned          LATENCY    = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [DATA_LEN-1:0]   araddr,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [2:0]            rresp,
  output logic [DATA_LEN-1:0]   rdata,
  output logic                  mem_cen,
  output logic [ADDR_WIDTH-1:0] mem_a,
  input  logic [DATA_LEN-1:0]   mem_q
);

  localparam int unsigned SHIFT = $clog2(DATA_LEN / 8);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_LATCH = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [2:0] RESP_OK  = 3'h0;
  localparam logic [2:0] RESP_ERR = 3'h2;

  logic [2:0]            state;
  logic [2:0]            state_nx;
  logic [3:0]            wcnt;
  logic [3:0]            wait_ld;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [DATA_LEN-1:0]   offset;
  logic [ADDR_WIDTH-1:0] idx_dec;
  logic                  dec_ok;
  logic                  ar_hs;
  logic                  r_hs;

`ifdef MEM_RESP_RAND_DELAY_EN
  logic [7:0] lfsr_q;

  rand_lfsr_8_bit u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (lfsr_q)
  );

  assign wait_ld = lfsr_q[3:0];
`else
  assign wait_ld = 4'(LATENCY);
`endif

  // Address decode: below base, beyond depth or not word-aligned is an error
  assign offset  = araddr - BASE_ADDR;
  assign idx_dec = offset[SHIFT +: ADDR_WIDTH];
  assign dec_ok  = (araddr >= BASE_ADDR)
                && ((offset >> (SHIFT + ADDR_WIDTH)) == '0)
                && (araddr[SHIFT-1:0] == '0);

  assign arready = (state == S_IDLE);
  assign mem_cen = (state != S_READ);
  assign ar_hs   = arvalid && (state == S_IDLE);
  assign r_hs    = rvalid && rready && (state == S_RESP);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (arvalid) state_nx = !dec_ok ? S_RESP : ((wait_ld == 4'd0) ? S_READ : S_WAIT);
      S_WAIT:  if (wcnt <= 4'd1) state_nx = S_READ;
      S_READ:  state_nx = S_LATCH;
      S_LATCH: state_nx = S_RESP;
      S_RESP:  if (rready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Control: FSM, wait counter and the latched word index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      wcnt  <= 4'd0;
      idx_q <= '0;
    end else begin
      state <= state_nx;
      if (ar_hs) begin
        wcnt  <= wait_ld;
        idx_q <= idx_dec;
      end else if ((state == S_WAIT) && (wcnt > 4'd1)) begin
        wcnt <= wcnt - 4'd1;
      end
    end
  end

  // SRAM address only moves when entering READ, so it holds its last value otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_a <= '0;
    end else if (state_nx == S_READ) begin
      mem_a <= (state == S_IDLE) ? idx_dec : idx_q;
    end
  end

  // Response stage: rdata/rresp are written once per request and held through RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rresp  <= RESP_OK;
      rdata  <= '0;
    end else if (ar_hs && !dec_ok) begin
      rvalid <= 1'b1;
      rresp  <= RESP_ERR;
      rdata  <= '0;
    end else if (state == S_LATCH) begin
      rvalid <= 1'b1;
      rresp  <= RESP_OK;
      rdata  <= mem_q;
    end else if (r_hs) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_read_responder.sv
// Scoreboard bench for mem_read_responder (DATA_LEN=32, ADDR_WIDTH=10, LATENCY=2).
module tb_mem_read_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [2:0]  rresp;
  logic [31:0] rdata;
  logic        mem_cen;
  logic [9:0]  mem_a;
  logic [31:0] mem_q;

  logic [31:0] mem [0:1023];
  logic [34:0] sb_q [$];
  logic [34:0] sb_e;
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_resp   = 0;
  int          n_push   = 0;
  bit          cen_seen;
  bit          rvalid_seen;

  mem_read_responder #(
    .DATA_LEN   (32),
    .BASE_ADDR  (32'h8000_0000),
    .ADDR_WIDTH (10),
    .LATENCY    (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .arvalid (arvalid),
    .arready (arready),
    .araddr  (araddr),
    .rvalid  (rvalid),
    .rready  (rready),
    .rresp   (rresp),
    .rdata   (rdata),
    .mem_cen (mem_cen),
    .mem_a   (mem_a),
    .mem_q   (mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: data appears the cycle after mem_cen low, held otherwise
  always @(posedge clk) if (!mem_cen) mem_q <= mem[mem_a];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [34:0] model(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (a < BASE || a[1:0] != 2'b00 || off >= 32'h1000) return {3'h2, 32'h0};
    return {3'h0, mem[off[11:2]]};
  endfunction

  always @(negedge clk) begin
    if (!mem_cen) cen_seen = 1'b1;
    if (rvalid) rvalid_seen = 1'b1;
    if (rst_n && rvalid && rready) begin
      n_resp++;
      if (sb_q.size() == 0) begin
        check_val("unexpected_resp", 64'd1, 64'd0);
      end else begin
        sb_e = sb_q.pop_front();
        check_val("sb_rresp", 64'(rresp), 64'(sb_e[34:32]));
        check_val("sb_rdata", 64'(rdata), 64'(sb_e[31:0]));
      end
    end
  end

  // Caller must be 1 time unit after a rising edge; returns 1 unit after the AR handshake edge
  task automatic ar(input logic [31:0] a, input bit push);
    int n;
    arvalid = 1'b1;
    araddr  = a;
    n = 0;
    @(negedge clk);
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!arready) check_val("ar_timeout", 64'd0, 64'd1);
    if (push) begin
      sb_q.push_back(model(a));
      n_push++;
    end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    araddr  = $urandom;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          n;
    for (int i = 0; i < 1024; i++) mem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_A5A5;
    for (int k = 0; k < 4; k++) mem[k] = 32'h1000 + k;
    mem[4] = 32'hDEAD_BEEF;

    rst_n   = 1'b0;
    arvalid = 1'b0;
    araddr  = '0;
    rready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_arready", 64'(arready), 64'd1);
    check_val("rst_rvalid",  64'(rvalid),  64'd0);
    check_val("rst_rresp",   64'(rresp),   64'd0);
    check_val("rst_rdata",   64'(rdata),   64'd0);
    check_val("rst_mem_cen", 64'(mem_cen), 64'd1);
    check_val("rst_mem_a",   64'(mem_a),   64'd0);

    // OK read with cycle-exact timing relative to handshake T
    @(posedge clk); #1;
    ar(32'h8000_0010, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      case (k)
        1: check_val("ok_cen_t1", 64'(mem_cen), 64'd1);
        2: check_val("ok_cen_t2", 64'(mem_cen), 64'd1);
        3: begin
          check_val("ok_cen_t3", 64'(mem_cen), 64'd0);
          check_val("ok_mem_a_t3", 64'(mem_a), 64'd4);
        end
        4: check_val("ok_rvalid_t4", 64'(rvalid), 64'd0);
        5: begin
          check_val("ok_rvalid_t5", 64'(rvalid), 64'd1);
          check_val("ok_rdata_t5", 64'(rdata), 64'hDEAD_BEEF);
          check_val("ok_rresp_t5", 64'(rresp), 64'd0);
        end
        default: begin
          check_val("ok_arready_t6", 64'(arready), 64'd1);
          check_val("ok_rvalid_t6", 64'(rvalid), 64'd0);
        end
      endcase
    end

    // Decode errors: out of range and misaligned
    for (int e = 0; e < 2; e++) begin
      a = (e == 0) ? 32'h8000_1000 : 32'h8000_0002;
      @(posedge clk); #1;
      cen_seen = 1'b0;
      ar(a, 1'b1);
      @(negedge clk);
      check_val("err_rvalid_t1", 64'(rvalid), 64'd1);
      check_val("err_rresp_t1",  64'(rresp),  64'd2);
      check_val("err_rdata_t1",  64'(rdata),  64'd0);
      @(negedge clk);
      check_val("err_arready_t2", 64'(arready), 64'd1);
      check_val("err_cen_never", 64'(cen_seen), 64'd0);
    end

    // Backpressure with a competing request held on AR
    @(posedge clk); #1;
    rready = 1'b0;
    ar(32'h8000_0008, 1'b1);
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_val("bp_rvalid_arrive", 64'(rvalid), 64'd1);
    @(posedge clk); #1;
    arvalid = 1'b1;
    araddr  = 32'h8000_000C;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("bp_rvalid_hold",  64'(rvalid),  64'd1);
      check_val("bp_rdata_hold",   64'(rdata),   64'h1002);
      check_val("bp_rresp_hold",   64'(rresp),   64'd0);
      check_val("bp_arready_low",  64'(arready), 64'd0);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    ar(32'h8000_000C, 1'b1);

    // Line fill: four sequential words
    for (int k = 0; k < 4; k++) ar(BASE + 32'(k * 4), 1'b1);

    // Reset pulsed in WAIT aborts the request
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    ar(32'h8000_0010, 1'b0);
    rst_n = 1'b0;
    rvalid_seen = 1'b0;
    @(negedge clk);
    check_val("abort_rvalid_in_rst", 64'(rvalid),  64'd0);
    check_val("abort_cen_in_rst",    64'(mem_cen), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ar(32'h8000_0010, 1'b1);
    repeat (8) @(negedge clk);
    check_val("abort_no_extra_resp", 64'(sb_q.size()), 64'd0);

    // Random mix of valid, out-of-range and misaligned addresses
    @(posedge clk); #1;
    for (int r = 0; r < 10; r++) begin
      a = BASE + (32'($urandom_range(0, 1100)) << 2);
      if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) a = 32'h7FFF_FFF0;
      ar(a, 1'b1);
    end

    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("sb_drained", 64'(sb_q.size()), 64'd0);
    check_val("resp_count", 64'(n_resp), 64'(n_push));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_read_responder.md
MEM_READ_RESPONDER -- requirements
Module: mem_read_responder

Interface
REQ-001 The block SHALL have parameter DATA_LEN, default 32, meaning data/address width (32 or 64).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h8000_0000, meaning byte address of memory word 0.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 10, meaning word-index width (depth 2^ADDR_WIDTH).
REQ-004 The block SHALL have parameter LATENCY, default 0, range 0..15, meaning extra wait cycles per read.
REQ-005 The block SHALL have port clk, input, 1 bit: clock, all state on rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port arvalid, input, 1 bit: read-address valid from the initiator.
REQ-008 The block SHALL have port arready, output, 1 bit: read-address ready.
REQ-009 The block SHALL have port araddr, input, DATA_LEN bits: byte read address.
REQ-010 The block SHALL have port rvalid, output, 1 bit: read-data valid.
REQ-011 The block SHALL have port rready, input, 1 bit: read-data ready from the initiator.
REQ-012 The block SHALL have port rresp, output, 3 bits: 3'h0 OK, 3'h2 error.
REQ-013 The block SHALL have port rdata, output, DATA_LEN bits: read data.
REQ-014 The block SHALL have port mem_cen, output, 1 bit: active-low SRAM chip enable (read-only, WEN tied high externally).
REQ-015 The block SHALL have port mem_a, output, ADDR_WIDTH bits: SRAM word address.
REQ-016 The block SHALL have port mem_q, input, DATA_LEN bits: SRAM read data, valid the cycle after mem_cen low, held while mem_cen high.

Function
REQ-017 The block SHALL implement FSM states IDLE, WAIT, READ, LATCH, RESP; exactly one request is outstanding at a time.
REQ-018 arready SHALL be 1 only in IDLE; arvalid/araddr SHALL be ignored in all other states.
REQ-019 The AR handshake (arvalid&arready) in cycle T SHALL latch araddr and decode it: OK iff araddr>=BASE_ADDR, word index=(araddr-BASE_ADDR)>>log2(DATA_LEN/8) < 2^ADDR_WIDTH, and the low log2(DATA_LEN/8) bits are zero.
REQ-020 On decode error: next state RESP, rvalid=1 in cycle T+1, rresp=3'h2, rdata=0, mem_cen never asserted.
REQ-021 On decode OK: WAIT for the loaded wait count (skipped if 0), then READ for one cycle with mem_cen=0 and mem_a=index[ADDR_WIDTH-1:0].
REQ-022 LATCH SHALL capture mem_q into rdata, set rresp=3'h0 and rvalid=1; for wait count W, rvalid SHALL first be high in cycle T+3+W.
REQ-023 In RESP, rvalid, rdata and rresp SHALL hold stable until rready=1; the R handshake SHALL return to IDLE with rvalid=0 and arready=1 in the following cycle.
REQ-024 mem_cen SHALL be 1 in every state except READ; mem_a SHALL hold its last value otherwise.
REQ-025 The wait counter SHALL be 4 bits, load on AR handshake, decrement in WAIT, leave WAIT when it reaches 1, and never wrap.
REQ-026 Illegal FSM encodings SHALL return to IDLE on the next edge.

Reset
REQ-027 Reset SHALL be asserted via rst_n low (asynchronous, active-low), clocked by clk.
REQ-028 On reset the outputs SHALL take arready=1, rvalid=0, rresp=3'h0, rdata=0, mem_cen=1, mem_a=0; the FSM SHALL go to IDLE; the wait counter SHALL go to 0.
REQ-029 Reset asserted in any state SHALL abort the request without a response; the first cycle after release SHALL accept a new request.

Configuration
REQ-030 Macro MEM_RESP_RAND_DELAY_EN defined: the wait count SHALL be loaded from a 4-bit rand_lfsr_8_bit output (0..15) at each AR handshake, and LATENCY SHALL be ignored.
REQ-031 Macro MEM_RESP_RAND_DELAY_EN undefined: the wait count SHALL equal LATENCY and no LFSR SHALL be instantiated; all verification below runs with the macro undefined.

Verification (DATA_LEN=32, BASE_ADDR=0x80000000, ADDR_WIDTH=10, LATENCY=2)
REQ-032 Reset scenario: hold rst_n=0 for 3 cycles, then release -> arready=1, rvalid=0, rresp=0, rdata=0, mem_cen=1, mem_a=0.
REQ-033 OK-read scenario: word 4=0xDEADBEEF, araddr=0x80000010 handshake at T, rready=1 -> mem_cen=0, mem_a=4 at T+3; rvalid=1, rdata=0xDEADBEEF, rresp=0 at T+5; arready=1 at T+6.
REQ-034 Error-read scenarios: araddr=0x80001000 (out of range) and araddr=0x80000002 (misaligned) -> rvalid at T+1, rresp=2, rdata=0, mem_cen stays 1.
REQ-035 Backpressure scenario: rready=0 for 4 cycles in RESP while arvalid=1 with a new address -> rvalid/rdata/rresp stable, arready=0, the new address is accepted only after the R handshake.
REQ-036 Line-fill scenario: back-to-back reads of 0x80000000/4/8/C with word k=0x1000+k -> four responses with rresp=0 and rdata 0x1000..0x1003, in order.
REQ-037 Reset-mid-WAIT scenario: rst_n pulsed low at T+1 -> no rvalid; after release a read of 0x80000010 completes normally.
